fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: ISSUE/WAIT/HOLD sequencer with one outstanding memory request.
// Optional stall counter on FetchStallCnt is built only when FETCH_PERF_EN is defined.
module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  EN,
  input  logic                  CLR,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_valid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] InstrF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic                  ValidF,
  output logic [31:0]           FetchStallCnt
);

  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] pc, req_addr, pc_plus4, target;
  logic [DATA_WIDTH-1:0] instr_q, pcf_q, pcplus4_q;
  logic                  valid_q, discard;
  logic                  unused_tgt_lsbs;

  assign pc_plus4        = pc + {{(DATA_WIDTH-3){1'b0}}, 3'd4};
  assign target          = {PCTargetE[DATA_WIDTH-1:2], 2'b00};
  assign unused_tgt_lsbs = ^PCTargetE[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_ISSUE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_ISSUE: state_nxt = PCSrcE ? S_ISSUE : S_WAIT;
      S_WAIT: begin
        if (imem_valid) state_nxt = (PCSrcE || discard) ? S_ISSUE : S_HOLD;
      end
      S_HOLD: begin
        if (PCSrcE || CLR || EN) state_nxt = S_ISSUE;
      end
      default: state_nxt = S_ISSUE;
    endcase
  end

  // Address is latched at issue so a redirect during WAIT cannot disturb the bus.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    case (state)
      S_ISSUE: imem_req = !rst;
      S_WAIT: begin
        imem_req  = !rst;
        imem_addr = req_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      discard   <= 1'b0;
      instr_q   <= '0;
      pcf_q     <= '0;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      if (state == S_ISSUE) req_addr <= pc;
      if (PCSrcE) begin
        pc      <= target;
        valid_q <= 1'b0;
        discard <= (state == S_WAIT) && !imem_valid;
      end else begin
        case (state)
          S_WAIT: begin
            if (imem_valid) begin
              if (discard) begin
                discard <= 1'b0;
              end else begin
                instr_q   <= imem_rdata;
                pcf_q     <= pc;
                pcplus4_q <= pc_plus4;
                valid_q   <= 1'b1;
              end
            end
          end
          S_HOLD: begin
            if (CLR || EN) begin
              pc      <= pc_plus4;
              valid_q <= 1'b0;
            end
          end
          default: ;
        endcase
        // Flush overrides any load in the same cycle.
        if (CLR) begin
          instr_q <= '0;
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign InstrF   = instr_q;
  assign PCF      = pcf_q;
  assign PCPlus4F = pcplus4_q;
  assign ValidF   = valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (state == S_WAIT && !imem_valid && stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign FetchStallCnt = stall_cnt;
`else
  assign FetchStallCnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency instruction memory model.
module tb_fetch_unit;
  logic        clk, rst, EN, CLR, PCSrcE;
  logic [31:0] PCTargetE, imem_addr, imem_rdata, InstrF, PCF, PCPlus4F, FetchStallCnt;
  logic        imem_req, imem_valid, ValidF;

  int          n_cmp, n_err;
  int          lat;
  logic        mbusy;
  int          mcnt;
  logic [31:0] maddr;

  fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .EN(EN), .CLR(CLR), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF), .FetchStallCnt(FetchStallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: a request seen in a cycle is answered `lat` cycles later; data = 0x00500093 + addr.
  initial begin
    imem_valid = 1'b0; imem_rdata = '0; mbusy = 1'b0; mcnt = 0; maddr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        imem_valid = 1'b0; mbusy = 1'b0;
      end else begin
        if (imem_valid) begin
          imem_valid = 1'b0; mbusy = 1'b0;
        end else if (mbusy) begin
          mcnt--;
          if (mcnt == 0) begin imem_valid = 1'b1; imem_rdata = 32'h00500093 + maddr; end
        end
        if (!mbusy && imem_req) begin mbusy = 1'b1; maddr = imem_addr; mcnt = lat; end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the negedge of the first ISSUE cycle.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(2);
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%0b exp=0", imem_req); end
    n_cmp++; if (ValidF !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%0b exp=0", ValidF); end
    n_cmp++; if (InstrF !== 32'h0) begin n_err++; $display("FAIL rst_instr got=%h exp=0", InstrF); end
    n_cmp++; if (PCF !== 32'h0) begin n_err++; $display("FAIL rst_pcf got=%h exp=0", PCF); end
    n_cmp++; if (PCPlus4F !== 32'h0) begin n_err++; $display("FAIL rst_pcp4 got=%h exp=0", PCPlus4F); end
    n_cmp++; if (FetchStallCnt !== 32'h0) begin n_err++; $display("FAIL rst_stallcnt got=%0d exp=0", FetchStallCnt); end
    do_reset();
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL first_req got=%0b exp=1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL first_addr got=%h exp=0", imem_addr); end
  endtask

  task automatic test_sequential();
    lat = 1; EN = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'(4*k)) begin n_err++; $display("FAIL seq_addr[%0d] got=%h exp=%h", k, imem_addr, 32'(4*k)); end
      step(2);
      n_cmp++; if (ValidF !== 1'b1) begin n_err++; $display("FAIL seq_valid[%0d] got=%0b exp=1", k, ValidF); end
      n_cmp++; if (PCF !== 32'(4*k)) begin n_err++; $display("FAIL seq_pcf[%0d] got=%h exp=%h", k, PCF, 32'(4*k)); end
      n_cmp++; if (PCPlus4F !== 32'(4*k+4)) begin n_err++; $display("FAIL seq_pcp4[%0d] got=%h exp=%h", k, PCPlus4F, 32'(4*k+4)); end
      n_cmp++; if (InstrF !== 32'h00500093 + 32'(4*k)) begin n_err++; $display("FAIL seq_instr[%0d] got=%h exp=%h", k, InstrF, 32'h00500093 + 32'(4*k)); end
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL seq_hold_req[%0d] got=%0b exp=0", k, imem_req); end
      step(1);
    end
  endtask

  task automatic test_stall_perf();
    logic [31:0] exp_cnt;
`ifdef FETCH_PERF_EN
    exp_cnt = 32'd3;
`else
    exp_cnt = 32'd0;
`endif
    lat = 4; EN = 1'b1;
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      step(1);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL slow_addr[%0d] got=%h req=%0b exp=0", c, imem_addr, imem_req); end
      n_cmp++; if (ValidF !== 1'b0) begin n_err++; $display("FAIL slow_early_valid[%0d] got=%0b exp=0", c, ValidF); end
    end
    step(1);
    n_cmp++; if (ValidF !== 1'b1) begin n_err++; $display("FAIL slow_valid got=%0b exp=1", ValidF); end
    n_cmp++; if (InstrF !== 32'h00500093) begin n_err++; $display("FAIL slow_instr got=%h exp=00500093", InstrF); end
    n_cmp++; if (FetchStallCnt !== exp_cnt) begin n_err++; $display("FAIL slow_stallcnt got=%0d exp=%0d", FetchStallCnt, exp_cnt); end
  endtask

  task automatic test_stall_en();
    lat = 1; EN = 1'b0;
    do_reset();
    step(2);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (ValidF !== 1'b1 || PCF !== 32'h0 || InstrF !== 32'h00500093) begin n_err++; $display("FAIL hold_outputs[%0d] got valid=%0b pcf=%h instr=%h exp 1/0/00500093", i, ValidF, PCF, InstrF); end
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL hold_req[%0d] got=%0b exp=0", i, imem_req); end
      step(1);
    end
    EN = 1'b1;
    step(1);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_err++; $display("FAIL resume_addr got=%h req=%0b exp=4", imem_addr, imem_req); end
  endtask

  task automatic test_redirect();
    logic seen8;
    bit   found;
    lat = 2; EN = 1'b1; seen8 = 1'b0; found = 0;
    do_reset();
    for (int i = 0; i < 30 && !found; i++) begin
      if (imem_req && imem_addr == 32'h8) found = 1;
      else step(1);
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL redir_reach8 got=timeout exp=request at 8"); end
    step(1);
    PCSrcE = 1'b1; PCTargetE = 32'h103;
    step(1);
    PCSrcE = 1'b0;
    if (ValidF && PCF == 32'h8) seen8 = 1'b1;
    n_cmp++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL redir_addr_held got=%h exp=8", imem_addr); end
    step(1);
    if (ValidF && PCF == 32'h8) seen8 = 1'b1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL redir_target got=%h req=%0b exp=100", imem_addr, imem_req); end
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (ValidF && PCF == 32'h8) seen8 = 1'b1;
    end
    n_cmp++; if (seen8 !== 1'b0) begin n_err++; $display("FAIL redir_dropped got=seen exp=never PCF 8"); end
    n_cmp++; if (ValidF !== 1'b1 || PCF !== 32'h100 || InstrF !== 32'h00500193) begin n_err++; $display("FAIL redir_fetch got valid=%0b pcf=%h instr=%h exp 1/100/00500193", ValidF, PCF, InstrF); end
  endtask

  task automatic test_clr_redirect();
    lat = 1; EN = 1'b0;
    do_reset();
    step(2);
    CLR = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h200;
    step(1);
    CLR = 1'b0; PCSrcE = 1'b0;
    n_cmp++; if (ValidF !== 1'b0) begin n_err++; $display("FAIL clrredir_valid got=%0b exp=0", ValidF); end
    n_cmp++; if (InstrF !== 32'h00500093) begin n_err++; $display("FAIL clrredir_instr got=%h exp=00500093", InstrF); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_err++; $display("FAIL clrredir_addr got=%h exp=200", imem_addr); end
    step(2);
    n_cmp++; if (ValidF !== 1'b1 || PCF !== 32'h200) begin n_err++; $display("FAIL clrredir_fetch got valid=%0b pcf=%h exp 1/200", ValidF, PCF); end
    CLR = 1'b1;
    step(1);
    CLR = 1'b0;
    n_cmp++; if (InstrF !== 32'h0 || ValidF !== 1'b0) begin n_err++; $display("FAIL clr_flush got instr=%h valid=%0b exp 0/0", InstrF, ValidF); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h204) begin n_err++; $display("FAIL clr_advance got=%h exp=204", imem_addr); end
  endtask

  task automatic test_wrap();
    lat = 1; EN = 1'b0;
    do_reset();
    step(2);
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    step(1);
    PCSrcE = 1'b0;
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_issue got=%h exp=fffffffc", imem_addr); end
    step(2);
    n_cmp++; if (ValidF !== 1'b1 || PCF !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pcf got valid=%0b pcf=%h exp 1/fffffffc", ValidF, PCF); end
    n_cmp++; if (PCPlus4F !== 32'h0) begin n_err++; $display("FAIL wrap_pcp4 got=%h exp=0", PCPlus4F); end
    n_cmp++; if (InstrF !== 32'h0050008F) begin n_err++; $display("FAIL wrap_instr got=%h exp=0050008f", InstrF); end
    EN = 1'b1;
    step(1);
    EN = 1'b0;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_next got=%h exp=0", imem_addr); end
  endtask

  task automatic test_async_reset();
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL arst_req got=%0b exp=0", imem_req); end
    n_cmp++; if (PCF !== 32'h0 || PCPlus4F !== 32'h0) begin n_err++; $display("FAIL arst_pc got pcf=%h pcp4=%h exp 0/0", PCF, PCPlus4F); end
    n_cmp++; if (InstrF !== 32'h0 || ValidF !== 1'b0) begin n_err++; $display("FAIL arst_instr got instr=%h valid=%0b exp 0/0", InstrF, ValidF); end
    lat = 1; EN = 1'b1;
    do_reset();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL arst_restart got=%h exp=0", imem_addr); end
    step(2);
    n_cmp++; if (ValidF !== 1'b1 || PCF !== 32'h0) begin n_err++; $display("FAIL arst_refetch got valid=%0b pcf=%h exp 1/0", ValidF, PCF); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; lat = 1;
    rst = 1'b1; EN = 1'b0; CLR = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    test_reset();
    test_sequential();
    test_stall_perf();
    test_stall_en();
    test_redirect();
    test_clr_redirect();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
